decode_stage: RTL
=================

Name: decode_stage

Overview:
- ID stage of the 5-stage MIPS-R2000 pipeline, directly downstream of IF.
- Consumes IF's registered pc_out/inst_out and decodes a MIPS-I integer subset.
- Reads a 32x32 register file with a write-back port and detects load-use hazards, driving hold_pc/hold_if back to IF.
- Registers operands, immediate, branch target and control into the ID/EX pipeline register, with bubble insertion on stall or flush.

Parameters:
- REG_COUNT, 32, number of GPRs (address width 5, fixed).
- WB_BYPASS, 1, when 1 a same-cycle write-back is forwarded to the register read.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- pc_in  in  32  IF pc_out (already PC+4 of inst_in)
- inst_in  in  32  IF inst_out (0 = NOP)
- flush  in  1  branch taken in EX (same signal as IF br)
- ex_mem_read  in  1  instruction currently in EX is lw
- ex_rt  in  5  destination of the lw in EX
- wb_en  in  1  write-back enable
- wb_addr  in  5  write-back register
- wb_data  in  32  write-back value
- hold_pc  out  1  stall PC register
- hold_if  out  1  stall IF/ID register
- rs_data_ex, rt_data_ex  out  32 each  operand values
- imm_ex  out  32  extended immediate
- br_target_ex  out  32  pc_in + (sext(imm16)<<2)
- pc_ex  out  32  pc_in passed through
- rs_ex, rt_ex, rd_ex  out  5 each  source/destination indices (rd_ex = final write register)
- shamt_ex  out  5  shift amount
- alu_op_ex  out  4  ALU operation code
- alu_src_ex  out  1  1 = immediate operand
- reg_write_ex, mem_read_ex, mem_write_ex, branch_ex, branch_ne_ex, jr_ex, illegal_ex  out  1 each  control

Behaviour:
- Reset (rst_n=0, async): every register file entry is 0, every *_ex output is 0, and hold_pc/hold_if are 0.
- Decoded subset, R-type by funct: add, addu, sub, subu, and, or, xor, nor, slt, sltu, sll, srl, sra, jr.
- Decoded subset, I-type: addi, addiu, andi, ori, xori, slti, sltiu, lui, lw, sw, beq, bne.
- Anything else sets illegal_ex=1 with all other control 0.
- Immediate: zero-extended for andi/ori/xori; lui gives {imm16,16'h0}; all others sign-extended.
- Destination: R-type uses rd; I-type writes use rt. reg_write_ex is forced 0 when the destination is $0.
- Register file: write on posedge clk when wb_en and wb_addr!=0. $0 always reads 0.
- Reads are combinational. With WB_BYPASS=1, wb_en && wb_addr==rs (or rt) && addr!=0 returns wb_data in the same cycle.
- Stall (combinational): stall = ex_mem_read && ex_rt!=0 && (ex_rt==rs || (ex_rt==rt && inst reads rt)).
  - "Reads rt": R-type, sw, beq, bne.
  - hold_pc = hold_if = stall && !flush.
- ID/EX update on every posedge clk (1-cycle latency):
  - flush=1: load a bubble (all control 0, all data 0). Flush has priority over stall.
  - else stall=1: load a bubble. IF holds, so the same inst_in is re-decoded next cycle.
  - else: load the decoded fields.
- inst_in = 0 decodes as sll $0 and produces no architectural effect.
- Arithmetic: br_target_ex is a 32-bit wrap-around sum, overflow ignored. No overflow trap is generated in ID.

Decomposition:
- Package mips_pkg: opcode/funct localparams, alu_op encoding (ADD=0, SUB=1, AND=2, OR=3, XOR=4, NOR=5, SLT=6, SLTU=7, SLL=8, SRL=9, SRA=10, LUI=11), and a packed id_ex_ctrl_t struct.
- Sub-module decode_regfile: 2 read ports, 1 write port, async reset, with the bypass logic.

Test Plan:
- Reset then release: all outputs 0. inst_in=0 -> next cycle reg_write_ex=0 and illegal_ex=0.
- wb $3=0x0000_00AA. Then inst addi $4,$3,-1 (0x2064FFFF) -> rs_data_ex=0xAA, imm_ex=0xFFFF_FFFF, alu_op_ex=ADD, alu_src_ex=1, rd_ex=4.
- Same-cycle bypass: wb_en=1, wb_addr=5, wb_data=0x1234 while decoding add $6,$5,$0 -> rs_data_ex=0x1234. Write to $0 -> reads stay 0.
- Load-use: ex_mem_read=1, ex_rt=2, inst add $7,$2,$1 -> hold_pc=hold_if=1 and the next cycle holds a bubble. Same case with ex_rt=0 -> no stall.
- Flush during stall: flush=1 with a stall condition present -> hold_pc=hold_if=0 and ID/EX is a bubble.
- beq $1,$2,-4 with pc_in=0x100 -> br_target_ex=0xF0, branch_ex=1. Opcode 0x3F -> illegal_ex=1.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared MIPS-I decode constants, ALU op encoding and the ID/EX register layout.
package mips_pkg;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0a;
    localparam logic [5:0] OP_SLTIU = 6'h0b;
    localparam logic [5:0] OP_ANDI  = 6'h0c;
    localparam logic [5:0] OP_ORI   = 6'h0d;
    localparam logic [5:0] OP_XORI  = 6'h0e;
    localparam logic [5:0] OP_LUI   = 6'h0f;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2b;

    localparam logic [5:0] FN_SLL  = 6'h00;
    localparam logic [5:0] FN_SRL  = 6'h02;
    localparam logic [5:0] FN_SRA  = 6'h03;
    localparam logic [5:0] FN_JR   = 6'h08;
    localparam logic [5:0] FN_ADD  = 6'h20;
    localparam logic [5:0] FN_ADDU = 6'h21;
    localparam logic [5:0] FN_SUB  = 6'h22;
    localparam logic [5:0] FN_SUBU = 6'h23;
    localparam logic [5:0] FN_AND  = 6'h24;
    localparam logic [5:0] FN_OR   = 6'h25;
    localparam logic [5:0] FN_XOR  = 6'h26;
    localparam logic [5:0] FN_NOR  = 6'h27;
    localparam logic [5:0] FN_SLT  = 6'h2a;
    localparam logic [5:0] FN_SLTU = 6'h2b;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_NOR  = 4'd5,
        ALU_SLT  = 4'd6,
        ALU_SLTU = 4'd7,
        ALU_SLL  = 4'd8,
        ALU_SRL  = 4'd9,
        ALU_SRA  = 4'd10,
        ALU_LUI  = 4'd11
    } alu_op_e;

    typedef struct packed {
        alu_op_e alu_op;
        logic    alu_src;
        logic    reg_write;
        logic    mem_read;
        logic    mem_write;
        logic    branch;
        logic    branch_ne;
        logic    jr;
        logic    illegal;
    } id_ex_ctrl_t;

    typedef struct packed {
        id_ex_ctrl_t ctrl;
        logic [31:0] rs_data;
        logic [31:0] rt_data;
        logic [31:0] imm;
        logic [31:0] br_target;
        logic [31:0] pc;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic [4:0]  rd;
        logic [4:0]  shamt;
    } id_ex_t;

    function automatic logic [31:0] sext16(input logic [15:0] v);
        return {{16{v[15]}}, v};
    endfunction

endpackage

// File: rtl/decode_regfile.sv
// GPR file: two combinational read ports, one write port, optional same-cycle write-back forwarding.
module decode_regfile #(
    parameter int REG_COUNT = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [4:0]  ra_rs,
    input  logic [4:0]  ra_rt,
    input  logic        we,
    input  logic [4:0]  wa,
    input  logic [31:0] wd,
    output logic [31:0] rs_data,
    output logic [31:0] rt_data
);

    logic [REG_COUNT-1:0][31:0] regs;
    logic hit_rs, hit_rt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            regs <= '0;
        else if (we && wa != 5'd0)
            regs[wa] <= wd;
    end

    assign hit_rs = WB_BYPASS && we && (wa == ra_rs);
    assign hit_rt = WB_BYPASS && we && (wa == ra_rt);

    // $0 is hardwired; it wins over both storage and the bypass
    assign rs_data = (ra_rs == 5'd0) ? 32'd0 : hit_rs ? wd : regs[ra_rs];
    assign rt_data = (ra_rt == 5'd0) ? 32'd0 : hit_rt ? wd : regs[ra_rt];

endmodule

// File: rtl/decode_stage.sv
// ID stage: decodes the MIPS-I integer subset, reads GPRs, detects load-use hazards
// and loads the ID/EX pipeline register (bubble on flush or stall).
module decode_stage
    import mips_pkg::*;
#(
    parameter int REG_COUNT = 32,
    parameter bit WB_BYPASS = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_in,
    input  logic [31:0] inst_in,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [4:0]  ex_rt,
    input  logic        wb_en,
    input  logic [4:0]  wb_addr,
    input  logic [31:0] wb_data,
    output logic        hold_pc,
    output logic        hold_if,
    output logic [31:0] rs_data_ex,
    output logic [31:0] rt_data_ex,
    output logic [31:0] imm_ex,
    output logic [31:0] br_target_ex,
    output logic [31:0] pc_ex,
    output logic [4:0]  rs_ex,
    output logic [4:0]  rt_ex,
    output logic [4:0]  rd_ex,
    output logic [4:0]  shamt_ex,
    output logic [3:0]  alu_op_ex,
    output logic        alu_src_ex,
    output logic        reg_write_ex,
    output logic        mem_read_ex,
    output logic        mem_write_ex,
    output logic        branch_ex,
    output logic        branch_ne_ex,
    output logic        jr_ex,
    output logic        illegal_ex
);

    logic [5:0]  opcode, funct;
    logic [4:0]  rs, rt, rd, dest;
    logic [15:0] imm16;
    logic [31:0] rs_val, rt_val, imm;
    logic        legal, reads_rt, stall;
    id_ex_ctrl_t ctrl;
    id_ex_t      d, q;

    assign opcode = inst_in[31:26];
    assign rs     = inst_in[25:21];
    assign rt     = inst_in[20:16];
    assign rd     = inst_in[15:11];
    assign funct  = inst_in[5:0];
    assign imm16  = inst_in[15:0];

    decode_regfile #(.REG_COUNT(REG_COUNT), .WB_BYPASS(WB_BYPASS)) u_rf (
        .clk     (clk),
        .rst_n   (rst_n),
        .ra_rs   (rs),
        .ra_rt   (rt),
        .we      (wb_en),
        .wa      (wb_addr),
        .wd      (wb_data),
        .rs_data (rs_val),
        .rt_data (rt_val)
    );

    always_comb begin
        ctrl  = '0;
        legal = 1'b1;
        case (opcode)
            OP_RTYPE: begin
                ctrl.reg_write = 1'b1;
                case (funct)
                    FN_ADD, FN_ADDU: ctrl.alu_op = ALU_ADD;
                    FN_SUB, FN_SUBU: ctrl.alu_op = ALU_SUB;
                    FN_AND:          ctrl.alu_op = ALU_AND;
                    FN_OR:           ctrl.alu_op = ALU_OR;
                    FN_XOR:          ctrl.alu_op = ALU_XOR;
                    FN_NOR:          ctrl.alu_op = ALU_NOR;
                    FN_SLT:          ctrl.alu_op = ALU_SLT;
                    FN_SLTU:         ctrl.alu_op = ALU_SLTU;
                    FN_SLL:          ctrl.alu_op = ALU_SLL;
                    FN_SRL:          ctrl.alu_op = ALU_SRL;
                    FN_SRA:          ctrl.alu_op = ALU_SRA;
                    FN_JR: begin
                        ctrl.reg_write = 1'b0;
                        ctrl.jr        = 1'b1;
                    end
                    default:         legal = 1'b0;
                endcase
            end
            OP_ADDI, OP_ADDIU: begin ctrl.alu_op = ALU_ADD;  ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_SLTI:           begin ctrl.alu_op = ALU_SLT;  ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_SLTIU:          begin ctrl.alu_op = ALU_SLTU; ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_ANDI:           begin ctrl.alu_op = ALU_AND;  ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_ORI:            begin ctrl.alu_op = ALU_OR;   ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_XORI:           begin ctrl.alu_op = ALU_XOR;  ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_LUI:            begin ctrl.alu_op = ALU_LUI;  ctrl.alu_src = 1'b1; ctrl.reg_write = 1'b1; end
            OP_LW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.reg_write = 1'b1;
                ctrl.mem_read  = 1'b1;
            end
            OP_SW: begin
                ctrl.alu_src   = 1'b1;
                ctrl.mem_write = 1'b1;
            end
            OP_BEQ: begin ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1; end
            OP_BNE: begin ctrl.alu_op = ALU_SUB; ctrl.branch = 1'b1; ctrl.branch_ne = 1'b1; end
            default: legal = 1'b0;
        endcase

        if (!legal) begin
            ctrl         = '0;
            ctrl.illegal = 1'b1;
        end

        dest = (opcode == OP_RTYPE) ? rd : rt;
        if (dest == 5'd0)
            ctrl.reg_write = 1'b0;
    end

    always_comb begin
        case (opcode)
            OP_LUI:                imm = {imm16, 16'h0000};
            OP_ANDI, OP_ORI, OP_XORI: imm = {16'h0000, imm16};
            default:               imm = sext16(imm16);
        endcase
    end

    // rs is treated as a source for every instruction; rt only where it is really read
    assign reads_rt = (opcode == OP_RTYPE) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ)   || (opcode == OP_BNE);
    assign stall    = ex_mem_read && (ex_rt != 5'd0) &&
                      ((ex_rt == rs) || ((ex_rt == rt) && reads_rt));
    assign hold_pc  = rst_n && stall && !flush;
    assign hold_if  = hold_pc;

    always_comb begin
        d           = '0;
        d.ctrl      = ctrl;
        d.rs_data   = rs_val;
        d.rt_data   = rt_val;
        d.imm       = imm;
        d.br_target = pc_in + (sext16(imm16) << 2);
        d.pc        = pc_in;
        d.rs        = rs;
        d.rt        = rt;
        d.rd        = dest;
        d.shamt     = inst_in[10:6];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            q <= '0;
        else if (flush || stall)
            q <= '0;
        else
            q <= d;
    end

    assign rs_data_ex   = q.rs_data;
    assign rt_data_ex   = q.rt_data;
    assign imm_ex       = q.imm;
    assign br_target_ex = q.br_target;
    assign pc_ex        = q.pc;
    assign rs_ex        = q.rs;
    assign rt_ex        = q.rt;
    assign rd_ex        = q.rd;
    assign shamt_ex     = q.shamt;
    assign alu_op_ex    = q.ctrl.alu_op;
    assign alu_src_ex   = q.ctrl.alu_src;
    assign reg_write_ex = q.ctrl.reg_write;
    assign mem_read_ex  = q.ctrl.mem_read;
    assign mem_write_ex = q.ctrl.mem_write;
    assign branch_ex    = q.ctrl.branch;
    assign branch_ne_ex = q.ctrl.branch_ne;
    assign jr_ex        = q.ctrl.jr;
    assign illegal_ex   = q.ctrl.illegal;

endmodule
